smi_mem_lib_write_burst_test_source: RTL and testbench
======================================================

# smi_mem_lib_write_burst_test_source

Parametrised multi-burst write test source for the SMI memory access library. It accepts one test descriptor and issues a sequence of write bursts to the write burst controller, with a configurable address stride between bursts and a selectable data pattern (counting or walking-rotate). It consumes every per-burst write status itself and returns one aggregated test result with a failure count. It sits between the test harness and the memory write burst controller.

## Interface
Parameters:
- DATA_WIDTH, 64, write data width in bits; legal values 8 to 512, power of two.
- COUNT_WIDTH, 16, width of the burst count and the failure count.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  asynchronous active-low reset.
- testParamsValid  in  1  test descriptor valid.
- testParamBurstAddr  in  64  start address of the first burst.
- testParamBurstLen  in  32  beats per burst.
- testParamBurstOpts  in  8  burst options, passed through unchanged.
- testParamBurstCount  in  COUNT_WIDTH  number of bursts.
- testParamAddrStride  in  64  address increment between bursts.
- testParamMode  in  1  0 = counting, 1 = rotate-left.
- testParamDataInit  in  DATA_WIDTH  first data beat.
- testParamDataIncr  in  DATA_WIDTH  counting increment; ignored in mode 1.
- testParamsStop  out  1  descriptor back-pressure.
- testDoneValid  out  1  test result valid.
- testDoneStatusOk  out  1  1 when every burst reported OK.
- testDoneFailCount  out  COUNT_WIDTH  number of bursts with status not OK.
- testDoneStop  in  1  result back-pressure.
- writeParamsValid  out  1  burst parameters valid.
- writeParamBurstAddr  out  64  current burst address.
- writeParamBurstLen  out  32  current burst length.
- writeParamBurstOpts  out  8  current burst options.
- writeParamsStop  in  1  burst parameter back-pressure.
- writeDataValid  out  1  write data valid.
- writeDataValue  out  DATA_WIDTH  write data.
- writeDataStop  in  1  write data back-pressure.
- writeDoneValid  in  1  per-burst status valid.
- writeDoneStatusOk  in  1  per-burst status.
- writeDoneStop  out  1  per-burst status back-pressure.

## Operation
- Handshake convention: a transfer occurs in any cycle where valid=1 and stop=0.
- The block has five states: Idle, SetParams, WriteData, GetStatus, Report.
- **Idle**
  - testParamsStop=0.
  - On descriptor transfer, latch all parameters, load the beat counter with the burst length and the burst counter with the burst count, and clear the fail count and the error flag.
  - If the burst count is 0 or the burst length is 0, go to Report: count=0 reports OK with fail count 0; len=0 reports not OK with fail count 0. No write traffic is generated in either case.
  - Otherwise go to SetParams.
- **SetParams**
  - writeParamsValid=1.
  - On transfer, go to WriteData.
- **WriteData**
  - writeDataValid=1 and writeDataValue=the current pattern register.
  - On each beat transfer, the pattern advances:
    - mode 0: value + incr, modulo 2^DATA_WIDTH;
    - mode 1: rotate left by 1 bit.
  - The beat counter decrements on each beat. The beat transferred with counter==1 moves the FSM to GetStatus.
- **GetStatus**
  - writeDoneStop=0; writeDoneStop=1 in every other state.
  - On status transfer, if status is not OK, increment the fail count (saturating at all-ones) and set the error flag.
  - If burst counter==1, go to Report.
  - Otherwise:
    - decrement the burst counter;
    - add the stride to the address (modulo 2^64);
    - reload the beat counter with the burst length;
    - go to SetParams.
  - The data pattern continues across bursts and is not reinitialised.
- **Report**
  - testDoneValid=1, testDoneStatusOk=~error flag, testDoneFailCount=fail count.
  - On transfer, go to Idle.
- Outputs are held stable while their valid is asserted and stop is high.

## Timing
- Reset:
  - All registers clear asynchronously on rstn=0, and the FSM enters Idle.
  - During reset: testParamsStop=0 and all valids are 0. Address, length, options, data value and fail count are 0; testDoneStatusOk=0; writeDoneStop=1.
  - Reset mid-test abandons the test immediately. No status is drained.
- Latency:
  - Descriptor transfer to writeParamsValid is 1 cycle.
  - Param transfer to first writeDataValid is 1 cycle.
  - A beat can transfer every cycle.
  - Status transfer to the next writeParamsValid, or to testDoneValid, is 1 cycle.
- Status arriving early: writeDoneValid asserted before GetStatus is ignored and stalled by writeDoneStop=1.
- Registered values: all outputs are driven from registers or decoded from the state register. There are no combinational paths from stop inputs to data outputs. Valids do not depend on stop inputs.

## Test plan
- Single burst, counting mode: addr=0x1000, len=4, count=1, init=5, incr=3, no stalls.
  - Data must be 5, 8, 11, 14.
  - One write params transfer.
  - Status OK gives StatusOk=1, FailCount=0.
- Multi-burst with stride: count=3, len=2, addr=0x100, stride=0x40.
  - Params addresses must be 0x100, 0x140, 0x180.
  - Data must continue init..init+5*incr across bursts.
  - Result must be reported once.
- Rotate mode with DATA_WIDTH=8: init=0x81, len=3.
  - Data must be 0x81, 0x03, 0x06.
- Back-pressure: random stop on writeParams, writeData, testDone.
  - No beat lost or duplicated.
  - Outputs stable while stalled.
  - Early writeDoneValid is held off until GetStatus.
- Failures and degenerate descriptors:
  - count=4 with statuses OK, BAD, OK, BAD must give StatusOk=0, FailCount=2.
  - count=0 must give an immediate OK result with no write traffic.
  - len=0 must give StatusOk=0 with no write traffic.
- Asynchronous reset mid-burst: assert rstn=0 during WriteData.
  - All valids must drop within the same cycle.
  - Afterwards the block must be in Idle with testParamsStop=0.
  - A new test must then run correctly.

Source files
------------

// File: rtl/smi_mem_lib_write_burst_test_source.sv
// rtl/smi_mem_lib_write_burst_test_source.sv - multi-burst write test source with counting/rotate data patterns
// Issues strided write bursts, absorbs per-burst status and reports one aggregated result.
module smi_mem_lib_write_burst_test_source #(
  parameter int DATA_WIDTH  = 64,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   testParamsValid,
  input  logic [63:0]            testParamBurstAddr,
  input  logic [31:0]            testParamBurstLen,
  input  logic [7:0]             testParamBurstOpts,
  input  logic [COUNT_WIDTH-1:0] testParamBurstCount,
  input  logic [63:0]            testParamAddrStride,
  input  logic                   testParamMode,
  input  logic [DATA_WIDTH-1:0]  testParamDataInit,
  input  logic [DATA_WIDTH-1:0]  testParamDataIncr,
  output logic                   testParamsStop,
  output logic                   testDoneValid,
  output logic                   testDoneStatusOk,
  output logic [COUNT_WIDTH-1:0] testDoneFailCount,
  input  logic                   testDoneStop,
  output logic                   writeParamsValid,
  output logic [63:0]            writeParamBurstAddr,
  output logic [31:0]            writeParamBurstLen,
  output logic [7:0]             writeParamBurstOpts,
  input  logic                   writeParamsStop,
  output logic                   writeDataValid,
  output logic [DATA_WIDTH-1:0]  writeDataValue,
  input  logic                   writeDataStop,
  input  logic                   writeDoneValid,
  input  logic                   writeDoneStatusOk,
  output logic                   writeDoneStop
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET_PARAMS,
    ST_WRITE_DATA,
    ST_GET_STATUS,
    ST_REPORT
  } state_t;

  localparam logic [COUNT_WIDTH-1:0] CNT_ONE = COUNT_WIDTH'(1);

  state_t                 state_q, state_d;
  logic [63:0]            addr_q, addr_d;
  logic [63:0]            stride_q, stride_d;
  logic [31:0]            len_q, len_d;
  logic [31:0]            beat_q, beat_d;
  logic [7:0]             opts_q, opts_d;
  logic [COUNT_WIDTH-1:0] burst_q, burst_d;
  logic [COUNT_WIDTH-1:0] fail_q, fail_d;
  logic                   mode_q, mode_d;
  logic                   err_q, err_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [DATA_WIDTH-1:0]  incr_q, incr_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      opts_q   <= '0;
      burst_q  <= '0;
      fail_q   <= '0;
      mode_q   <= 1'b0;
      err_q    <= 1'b0;
      data_q   <= '0;
      incr_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      stride_q <= stride_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      opts_q   <= opts_d;
      burst_q  <= burst_d;
      fail_q   <= fail_d;
      mode_q   <= mode_d;
      err_q    <= err_d;
      data_q   <= data_d;
      incr_q   <= incr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    stride_d = stride_q;
    len_d    = len_q;
    beat_d   = beat_q;
    opts_d   = opts_q;
    burst_d  = burst_q;
    fail_d   = fail_q;
    mode_d   = mode_q;
    err_d    = err_q;
    data_d   = data_q;
    incr_d   = incr_q;
    case (state_q)
      ST_IDLE: begin
        if (testParamsValid) begin
          addr_d   = testParamBurstAddr;
          stride_d = testParamAddrStride;
          len_d    = testParamBurstLen;
          beat_d   = testParamBurstLen;
          opts_d   = testParamBurstOpts;
          burst_d  = testParamBurstCount;
          mode_d   = testParamMode;
          data_d   = testParamDataInit;
          incr_d   = testParamDataIncr;
          fail_d   = '0;
          err_d    = 1'b0;
          // A zero burst count wins over a zero length: nothing was asked for, so OK.
          if (testParamBurstCount == '0) begin
            state_d = ST_REPORT;
          end else if (testParamBurstLen == 32'd0) begin
            err_d   = 1'b1;
            state_d = ST_REPORT;
          end else begin
            state_d = ST_SET_PARAMS;
          end
        end
      end
      ST_SET_PARAMS: begin
        if (!writeParamsStop) state_d = ST_WRITE_DATA;
      end
      ST_WRITE_DATA: begin
        if (!writeDataStop) begin
          data_d = mode_q ? {data_q[DATA_WIDTH-2:0], data_q[DATA_WIDTH-1]} : data_q + incr_q;
          beat_d = beat_q - 32'd1;
          if (beat_q == 32'd1) state_d = ST_GET_STATUS;
        end
      end
      ST_GET_STATUS: begin
        if (writeDoneValid) begin
          if (!writeDoneStatusOk) begin
            err_d = 1'b1;
            if (fail_q != '1) fail_d = fail_q + CNT_ONE;
          end
          if (burst_q == CNT_ONE) begin
            state_d = ST_REPORT;
          end else begin
            burst_d = burst_q - CNT_ONE;
            addr_d  = addr_q + stride_q;
            beat_d  = len_q;
            state_d = ST_SET_PARAMS;
          end
        end
      end
      ST_REPORT: begin
        if (!testDoneStop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign testParamsStop      = (state_q != ST_IDLE);
  assign writeParamsValid    = (state_q == ST_SET_PARAMS);
  assign writeDataValid      = (state_q == ST_WRITE_DATA);
  assign writeDoneStop       = (state_q != ST_GET_STATUS);
  assign testDoneValid       = (state_q == ST_REPORT);
  assign testDoneStatusOk    = (state_q == ST_REPORT) && !err_q;
  assign testDoneFailCount   = fail_q;
  assign writeParamBurstAddr = addr_q;
  assign writeParamBurstLen  = len_q;
  assign writeParamBurstOpts = opts_q;
  assign writeDataValue      = data_q;

endmodule

// File: tb/tb_smi_mem_lib_write_burst_test_source.sv
// tb/tb_smi_mem_lib_write_burst_test_source.sv - directed self-checking bench for the write burst test source
module tb_smi_mem_lib_write_burst_test_source;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        testParamsValid = 1'b0;
  logic [63:0] testParamBurstAddr = '0;
  logic [31:0] testParamBurstLen = '0;
  logic [7:0]  testParamBurstOpts = '0;
  logic [15:0] testParamBurstCount = '0;
  logic [63:0] testParamAddrStride = '0;
  logic        testParamMode = 1'b0;
  logic [7:0]  testParamDataInit = '0;
  logic [7:0]  testParamDataIncr = '0;
  logic        testParamsStop;
  logic        testDoneValid;
  logic        testDoneStatusOk;
  logic [15:0] testDoneFailCount;
  logic        testDoneStop = 1'b0;
  logic        writeParamsValid;
  logic [63:0] writeParamBurstAddr;
  logic [31:0] writeParamBurstLen;
  logic [7:0]  writeParamBurstOpts;
  logic        writeParamsStop = 1'b0;
  logic        writeDataValid;
  logic [7:0]  writeDataValue;
  logic        writeDataStop = 1'b0;
  logic        writeDoneValid = 1'b0;
  logic        writeDoneStatusOk = 1'b0;
  logic        writeDoneStop;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] exp_addr[$];
  logic [7:0]  exp_data[$];
  logic        exp_ok;
  logic [15:0] exp_fail;

  smi_mem_lib_write_burst_test_source #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
    .clk(clk), .rstn(rstn),
    .testParamsValid(testParamsValid), .testParamBurstAddr(testParamBurstAddr),
    .testParamBurstLen(testParamBurstLen), .testParamBurstOpts(testParamBurstOpts),
    .testParamBurstCount(testParamBurstCount), .testParamAddrStride(testParamAddrStride),
    .testParamMode(testParamMode), .testParamDataInit(testParamDataInit),
    .testParamDataIncr(testParamDataIncr), .testParamsStop(testParamsStop),
    .testDoneValid(testDoneValid), .testDoneStatusOk(testDoneStatusOk),
    .testDoneFailCount(testDoneFailCount), .testDoneStop(testDoneStop),
    .writeParamsValid(writeParamsValid), .writeParamBurstAddr(writeParamBurstAddr),
    .writeParamBurstLen(writeParamBurstLen), .writeParamBurstOpts(writeParamBurstOpts),
    .writeParamsStop(writeParamsStop), .writeDataValid(writeDataValid),
    .writeDataValue(writeDataValue), .writeDataStop(writeDataStop),
    .writeDoneValid(writeDoneValid), .writeDoneStatusOk(writeDoneStatusOk),
    .writeDoneStop(writeDoneStop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Acts as harness and write controller; called at #1 after a rising edge.
  task automatic run_test(input string name, input logic [63:0] a, input logic [31:0] l,
                          input logic [7:0] o, input logic [15:0] c, input logic [63:0] s,
                          input logic m, input logic [7:0] di, input logic [7:0] dinc,
                          input bit stall, input logic [15:0] bad_mask);
    logic [63:0] got_addr[$];
    logic [7:0]  got_data[$];
    int          done_cnt = 0;
    int          burst_idx = 0;
    int          beats = 0;
    int          cyc = 0;
    int          post = 0;
    logic        got_ok = 1'b0;
    logic [15:0] got_fail = '0;
    bit          armed = 0;
    bit          desc_x = 0;
    bit          pv_stall = 0, dv_stall = 0, tv_stall = 0;
    logic [63:0] pv_addr = '0;
    logic [7:0]  dv_val = '0;
    logic [15:0] tv_fail = '0;
    logic        tv_ok = 1'b0;
    testParamBurstAddr  = a;
    testParamBurstLen   = l;
    testParamBurstOpts  = o;
    testParamBurstCount = c;
    testParamAddrStride = s;
    testParamMode       = m;
    testParamDataInit   = di;
    testParamDataIncr   = dinc;
    testParamsValid     = 1'b1;
    while (post < 6 && cyc < 2000) begin
      if (pv_stall) begin
        chk({name, ":par_hold_v"}, 64'(writeParamsValid), 64'd1);
        chk({name, ":par_hold_a"}, writeParamBurstAddr, pv_addr);
      end
      if (dv_stall) begin
        chk({name, ":dat_hold_v"}, 64'(writeDataValid), 64'd1);
        chk({name, ":dat_hold_d"}, 64'(writeDataValue), 64'(dv_val));
      end
      if (tv_stall) begin
        chk({name, ":res_hold_v"}, 64'(testDoneValid), 64'd1);
        chk({name, ":res_hold_ok"}, 64'(testDoneStatusOk), 64'(tv_ok));
        chk({name, ":res_hold_fc"}, 64'(testDoneFailCount), 64'(tv_fail));
      end
      writeParamsStop   = stall ? ($urandom_range(0, 1) == 1) : 1'b0;
      writeDataStop     = stall ? ($urandom_range(0, 1) == 1) : 1'b0;
      testDoneStop      = stall ? ($urandom_range(0, 1) == 1) : 1'b0;
      writeDoneValid    = armed;
      writeDoneStatusOk = !bad_mask[burst_idx[3:0]];
      if (testParamsValid && !testParamsStop) desc_x = 1;
      if (writeDoneValid && got_data.size() < got_addr.size() * int'(l))
        chk({name, ":early_status_held"}, 64'(writeDoneStop), 64'd1);
      if (writeParamsValid && !writeParamsStop) begin
        got_addr.push_back(writeParamBurstAddr);
        chk({name, ":par_len"}, 64'(writeParamBurstLen), 64'(l));
        chk({name, ":par_opts"}, 64'(writeParamBurstOpts), 64'(o));
        if (stall) armed = 1;
      end
      if (writeDataValid && !writeDataStop) begin
        got_data.push_back(writeDataValue);
        beats++;
        if (beats == int'(l)) begin
          beats = 0;
          armed = 1;
        end
      end
      if (writeDoneValid && !writeDoneStop) begin
        chk({name, ":status_after_data"}, 64'(got_data.size()), 64'(got_addr.size() * int'(l)));
        burst_idx++;
        armed = 0;
      end
      if (testDoneValid && !testDoneStop) begin
        done_cnt++;
        got_ok   = testDoneStatusOk;
        got_fail = testDoneFailCount;
      end
      pv_stall = writeParamsValid && writeParamsStop;
      pv_addr  = writeParamBurstAddr;
      dv_stall = writeDataValid && writeDataStop;
      dv_val   = writeDataValue;
      tv_stall = testDoneValid && testDoneStop;
      tv_ok    = testDoneStatusOk;
      tv_fail  = testDoneFailCount;
      @(posedge clk);
      #1;
      cyc++;
      if (desc_x) testParamsValid = 1'b0;
      if (done_cnt > 0) post++;
    end
    writeParamsStop = 1'b0;
    writeDataStop   = 1'b0;
    testDoneStop    = 1'b0;
    writeDoneValid  = 1'b0;
    chk({name, ":timeout"}, 64'(cyc < 2000), 64'd1);
    chk({name, ":n_params"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    for (int i = 0; i < exp_addr.size(); i++)
      if (i < got_addr.size()) chk({name, $sformatf(":addr%0d", i)}, got_addr[i], exp_addr[i]);
    chk({name, ":n_beats"}, 64'(got_data.size()), 64'(exp_data.size()));
    for (int i = 0; i < exp_data.size(); i++)
      if (i < got_data.size()) chk({name, $sformatf(":data%0d", i)}, 64'(got_data[i]), 64'(exp_data[i]));
    chk({name, ":n_results"}, 64'(done_cnt), 64'd1);
    chk({name, ":status_ok"}, 64'(got_ok), 64'(exp_ok));
    chk({name, ":fail_count"}, 64'(got_fail), 64'(exp_fail));
    chk({name, ":idle_after"}, 64'(testParamsStop), 64'd0);
  endtask

  initial begin
    int cyc;
    #2;
    chk("rst:params_stop", 64'(testParamsStop), 64'd0);
    chk("rst:par_valid", 64'(writeParamsValid), 64'd0);
    chk("rst:dat_valid", 64'(writeDataValid), 64'd0);
    chk("rst:res_valid", 64'(testDoneValid), 64'd0);
    chk("rst:done_stop", 64'(writeDoneStop), 64'd1);
    chk("rst:addr", writeParamBurstAddr, 64'd0);
    chk("rst:len", 64'(writeParamBurstLen), 64'd0);
    chk("rst:data", 64'(writeDataValue), 64'd0);
    chk("rst:fail", 64'(testDoneFailCount), 64'd0);
    chk("rst:ok", 64'(testDoneStatusOk), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;

    exp_addr = {64'h1000};
    exp_data = {8'h05, 8'h08, 8'h0B, 8'h0E};
    exp_ok = 1'b1; exp_fail = 16'd0;
    run_test("single", 64'h1000, 32'd4, 8'h3C, 16'd1, 64'h0, 1'b0, 8'd5, 8'd3, 0, 16'h0);

    exp_addr = {64'h100, 64'h140, 64'h180};
    exp_data = {8'h10, 8'h17, 8'h1E, 8'h25, 8'h2C, 8'h33};
    exp_ok = 1'b1; exp_fail = 16'd0;
    run_test("stride", 64'h100, 32'd2, 8'h01, 16'd3, 64'h40, 1'b0, 8'h10, 8'h07, 0, 16'h0);

    exp_addr = {64'h0};
    exp_data = {8'h81, 8'h03, 8'h06};
    exp_ok = 1'b1; exp_fail = 16'd0;
    run_test("rotate", 64'h0, 32'd3, 8'h00, 16'd1, 64'h0, 1'b1, 8'h81, 8'h55, 0, 16'h0);

    exp_addr = {64'h2000, 64'h2010};
    exp_data = {8'hF0, 8'hF9, 8'h02, 8'h0B, 8'h14, 8'h1D};
    exp_ok = 1'b1; exp_fail = 16'd0;
    run_test("stall", 64'h2000, 32'd3, 8'hA5, 16'd2, 64'h10, 1'b0, 8'hF0, 8'h09, 1, 16'h0);

    exp_addr = {64'hFFFF_FFFF_FFFF_FFF0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h8};
    exp_data = {8'h01, 8'h02, 8'h04, 8'h08};
    exp_ok = 1'b0; exp_fail = 16'd2;
    run_test("fails", 64'hFFFF_FFFF_FFFF_FFF0, 32'd1, 8'h5A, 16'd4, 64'h8, 1'b1, 8'h01, 8'h00, 1, 16'b1010);

    exp_addr = {};
    exp_data = {};
    exp_ok = 1'b1; exp_fail = 16'd0;
    run_test("count0", 64'h4000, 32'd4, 8'h00, 16'd0, 64'h10, 1'b0, 8'h01, 8'h01, 0, 16'h0);

    exp_ok = 1'b0; exp_fail = 16'd0;
    run_test("len0", 64'h4000, 32'd0, 8'h00, 16'd2, 64'h10, 1'b0, 8'h01, 8'h01, 0, 16'h0);

    testParamBurstAddr  = 64'h3000;
    testParamBurstLen   = 32'd8;
    testParamBurstCount = 16'd2;
    testParamMode       = 1'b0;
    testParamDataInit   = 8'h40;
    testParamDataIncr   = 8'h01;
    testParamsValid     = 1'b1;
    @(posedge clk);
    #1;
    testParamsValid = 1'b0;
    cyc = 0;
    while (!writeDataValid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("arst:reached_data", 64'(writeDataValid), 64'd1);
    @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    chk("arst:dat_valid", 64'(writeDataValid), 64'd0);
    chk("arst:par_valid", 64'(writeParamsValid), 64'd0);
    chk("arst:res_valid", 64'(testDoneValid), 64'd0);
    chk("arst:params_stop", 64'(testParamsStop), 64'd0);
    chk("arst:done_stop", 64'(writeDoneStop), 64'd1);
    chk("arst:data", 64'(writeDataValue), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    chk("arst:idle", 64'(testParamsStop), 64'd0);

    exp_addr = {64'h1000};
    exp_data = {8'h05, 8'h08, 8'h0B, 8'h0E};
    exp_ok = 1'b1; exp_fail = 16'd0;
    run_test("after_rst", 64'h1000, 32'd4, 8'h3C, 16'd1, 64'h0, 1'b0, 8'd5, 8'd3, 0, 16'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
